// File: rtl/fixed_square_pkg.sv
// Shared fixed-point definitions for the sqrt / square datapath of the ray caster.
// Operands are 8.4 fixed point; squares are 16.8.
package fixed_square_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int INT_BITS     = 8;
    localparam int FRAC_BITS    = 4;
    localparam int OPERAND_BITS = INT_BITS + FRAC_BITS;
    localparam int PRODUCT_BITS = 2 * OPERAND_BITS;
    localparam int ITERS        = OPERAND_BITS;

endpackage

// File: rtl/fixed_square.sv
// Sequential shift-add squarer for 8.4 fixed-point operands.
// One partial product per cycle; saturates when operand bits 15:12 are set.
module fixed_square
    import fixed_square_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] square,
    output logic [7:0]  frac,
    output logic        overflow
);

    state_t                    state;
    logic [PRODUCT_BITS-1:0]   acc;
    logic [PRODUCT_BITS-1:0]   mcand;
    logic [OPERAND_BITS-1:0]   mplier;
    logic [3:0]                count;
    logic                      ovf;
    logic [PRODUCT_BITS-1:0]   acc_next;

    // Accumulator value after this cycle's partial product; also used to load
    // the result registers on the final iteration.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // NOTE: every register here is updated with <= so all branches see the
    // pre-edge values; a blocking = would make acc_next and count race.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            square    <= '0;
            frac      <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= {{(PRODUCT_BITS-OPERAND_BITS){1'b0}}, operand[OPERAND_BITS-1:0]};
                        mplier   <= operand[OPERAND_BITS-1:0];
                        acc      <= '0;
                        count    <= '0;
                        ovf      <= |operand[15:OPERAND_BITS];
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 4'd1;
                    if (count == 4'(ITERS - 1)) begin
                        out_valid <= 1'b1;
                        overflow  <= ovf;
                        square    <= ovf ? 16'hFFFF : acc_next[PRODUCT_BITS-1:8];
                        frac      <= ovf ? 8'hFF    : acc_next[7:0];
                        state     <= DONE;
                    end
                end

                DONE: begin
                    // Result registers hold while the consumer stalls.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        square    <= '0;
                        frac      <= '0;
                        overflow  <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_square.sv
// Directed bench for fixed_square: vectors, backpressure, ignored in_valid,
// mid-run reset and a sqrt round-trip sweep.
module tb_fixed_square;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] operand;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] square;
    logic [7:0]  frac;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    fixed_square dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .square    (square),
        .frac      (frac),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Integer square root: largest r with r*r <= v.
    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Full transaction: wait for in_ready, accept, wait for out_valid, take.
    task automatic do_op(input logic [15:0] op, output logic [15:0] sq,
                         output logic [7:0] fr, output logic ov, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL in_ready_timeout op=%h: in_ready still 0 after 50 cycles", op);
        end
        in_valid = 1'b1;
        operand  = op;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        sq = square;
        fr = frac;
        ov = overflow;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operand   = '0;
        #12;
        n_checks++;
        if ({in_ready, out_valid, square, frac, overflow} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b sq=%h fr=%h ov=%b, want rdy=1 vld=0 sq=0000 fr=00 ov=0",
                     in_ready, out_valid, square, frac, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [15:0] op;
        logic [15:0] sq;
        logic [7:0]  fr;
        logic        ov;
    } vec_t;

    task automatic test_vectors();
        vec_t vecs[8];
        logic [15:0] sq;
        logic [7:0]  fr;
        logic        ov;
        int          lat;
        vecs[0] = '{16'h0040, 16'h0010, 8'h00, 1'b0};
        vecs[1] = '{16'h0041, 16'h0010, 8'h81, 1'b0};
        vecs[2] = '{16'h0042, 16'h0011, 8'h04, 1'b0};
        vecs[3] = '{16'h0FFF, 16'hFFE0, 8'h01, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 8'h00, 1'b0};
        vecs[5] = '{16'h1000, 16'hFFFF, 8'hFF, 1'b1};
        vecs[6] = '{16'h0020, 16'h0004, 8'h00, 1'b0};
        vecs[7] = '{16'hF123, 16'hFFFF, 8'hFF, 1'b1};
        // Back-to-back: each do_op accepts as soon as in_ready returns.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].op, sq, fr, ov, lat);
            n_checks++;
            if (lat !== 12) begin
                n_fail++;
                $display("FAIL latency op=%h: got %0d cycles, want 12", vecs[i].op, lat);
            end
            n_checks++;
            if ({sq, fr, ov} !== {vecs[i].sq, vecs[i].fr, vecs[i].ov}) begin
                n_fail++;
                $display("FAIL vector op=%h: got sq=%h fr=%h ov=%b, want sq=%h fr=%h ov=%b",
                         vecs[i].op, sq, fr, ov, vecs[i].sq, vecs[i].fr, vecs[i].ov);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        in_valid = 1'b1;
        operand  = 16'h0041;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 12) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d cycles, want 12", n);
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({out_valid, in_ready, square, frac, overflow} !== {1'b1, 1'b0, 16'h0010, 8'h81, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b sq=%h fr=%h ov=%b, want vld=1 rdy=0 sq=0010 fr=81 ov=0",
                         i, out_valid, in_ready, square, frac, overflow);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_run_ignore();
        int n;
        in_valid = 1'b1;
        operand  = 16'h0040;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        in_valid = 1'b1;
        operand  = 16'h0FFF;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL run_in_ready: got %b, want 0", in_ready);
        end
        n = 4;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if ({n, square, frac} !== {32'd12, 16'h0010, 8'h00}) begin
            n_fail++;
            $display("FAIL run_ignore: got lat=%0d sq=%h fr=%h, want lat=12 sq=0010 fr=00", n, square, frac);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] sq;
        logic [7:0]  fr;
        logic        ov;
        int          lat;
        in_valid = 1'b1;
        operand  = 16'h0FFF;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, square, frac, overflow} !== {1'b0, 1'b1, 16'h0, 8'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_run_reset: got vld=%b rdy=%b sq=%h fr=%h ov=%b, want vld=0 rdy=1 sq=0000 fr=00 ov=0",
                     out_valid, in_ready, square, frac, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op(16'h0020, sq, fr, ov, lat);
        n_checks++;
        if ({lat, sq, fr, ov} !== {32'd12, 16'h0004, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_op: got lat=%0d sq=%h fr=%h ov=%b, want lat=12 sq=0004 fr=00 ov=0",
                     lat, sq, fr, ov);
        end
    endtask

    // Round trip: x -> 8.4 sqrt (floor(sqrt(x*256))) -> square must not exceed x.
    task automatic test_sweep();
        logic [15:0] sq;
        logic [7:0]  fr;
        logic        ov;
        int          lat;
        int          x;
        int          r;
        int          got;
        for (int k = 0; k <= 256; k++) begin
            x = (k == 256) ? 65535 : k * 257;
            r = isqrt(x * 256);
            do_op(16'(r), sq, fr, ov, lat);
            got = int'(sq) * 256 + int'(fr);
            n_checks++;
            if (got !== r * r || got > x * 256 || ov !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep x=%0d op=%h: got sq*256+fr=%0d ov=%b, want %0d (<= %0d) ov=0",
                         x, r, got, ov, r * r, x * 256);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_run_ignore();
        test_reset_mid_run();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
